// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between I-cache line refills (burst) and single-word data accesses.
// Latency: grant one cycle after request; each completion/valid one cycle after its mem_ack_i.
// Backpressure: a missing mem_ack_i holds the current beat; requesters hold req until their done pulse.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req_i,
    input  logic [ADDR_WIDTH-1:0]         i_addr_i,
    output logic [DATA_WIDTH-1:0]         i_rdata_o,
    output logic                          i_valid_o,
    output logic [$clog2(LINE_WORDS)-1:0] i_word_idx_o,
    output logic                          i_done_o,
    input  logic                          d_req_i,
    input  logic                          d_we_i,
    input  logic [ADDR_WIDTH-1:0]         d_addr_i,
    input  logic [DATA_WIDTH-1:0]         d_wdata_i,
    input  logic [3:0]                    d_be_i,
    output logic [DATA_WIDTH-1:0]         d_rdata_o,
    output logic                          d_done_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [3:0]                    mem_be_o,
    input  logic                          mem_ack_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(3);
    localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        I_BURST,
        D_ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_d_q, last_d_d;
    logic [IDX_W-1:0]        beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic                    i_valid_q, i_valid_d;
    logic [IDX_W-1:0]        i_idx_q, i_idx_d;
    logic                    i_done_q, i_done_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    d_done_q, d_done_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic                    busy_q, busy_d;

    logic i_elig, d_elig, grant_i, grant_d;

    // A requester still showing its done pulse holds a stale request; skip it.
    assign i_elig  = i_req_i && !i_done_q;
    assign d_elig  = d_req_i && !d_done_q;
    assign grant_i = i_elig && (!d_elig || last_d_q);
    assign grant_d = d_elig && !grant_i;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        beat_d      = beat_q;
        i_rdata_d   = i_rdata_q;
        i_valid_d   = 1'b0;
        i_idx_d     = i_idx_q;
        i_done_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_done_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d    = I_BURST;
                    last_d_d   = 1'b0;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'hF;
                    mem_addr_d = i_addr_i & ~LINE_MASK;
                end else if (grant_d) begin
                    state_d     = D_ACCESS;
                    last_d_d    = 1'b1;
                    beat_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_be_d    = d_we_i ? d_be_i : 4'hF;
                    mem_addr_d  = d_addr_i & ~WORD_MASK;
                    mem_wdata_d = d_wdata_i;
                end
            end
            I_BURST: begin
                if (mem_ack_i) begin
                    i_rdata_d  = mem_rdata_i;
                    i_idx_d    = beat_q;
                    i_valid_d  = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(4);
                    beat_d     = beat_q + IDX_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        i_done_d  = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            D_ACCESS: begin
                if (mem_ack_i) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            beat_q      <= '0;
            i_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            i_idx_q     <= '0;
            i_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            beat_q      <= beat_d;
            i_rdata_q   <= i_rdata_d;
            i_valid_q   <= i_valid_d;
            i_idx_q     <= i_idx_d;
            i_done_q    <= i_done_d;
            d_rdata_q   <= d_rdata_d;
            d_done_q    <= d_done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            busy_q      <= busy_d;
        end
    end

    assign i_rdata_o    = i_rdata_q;
    assign i_valid_o    = i_valid_q;
    assign i_word_idx_o = i_idx_q;
    assign i_done_o     = i_done_q;
    assign d_rdata_o    = d_rdata_q;
    assign d_done_o     = d_done_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = mem_be_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the shared port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata_o;
    logic        i_valid_o;
    logic [1:0]  i_word_idx_o;
    logic        i_done_o;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LINE_WORDS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_i      (i_req),
        .i_addr_i     (i_addr),
        .i_rdata_o    (i_rdata_o),
        .i_valid_o    (i_valid_o),
        .i_word_idx_o (i_word_idx_o),
        .i_done_o     (i_done_o),
        .d_req_i      (d_req),
        .d_we_i       (d_we),
        .d_addr_i     (d_addr),
        .d_wdata_i    (d_wdata),
        .d_be_i       (d_be),
        .d_rdata_o    (d_rdata_o),
        .d_done_o     (d_done_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected visible outputs for one cycle.
    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_be;
        logic        busy;
        logic        i_valid;
        logic [1:0]  i_idx;
        logic [31:0] i_rdata;
        logic        i_done;
        logic        d_done;
        logic [31:0] d_rdata;
    } exp_t;

    exp_t cur, nxt;
    bit   cmp_en = 0;

    // Transaction-level view: who owns the port, its base address and how many beats are done.
    int          owner = 0;    // 0 none, 1 refill, 2 data
    logic [31:0] base;
    int          beats;
    bit          last_was_d;
    logic        t_we;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;

    task automatic model_step();
        bit want_i, want_d;
        nxt         = cur;
        nxt.i_valid = 1'b0;
        nxt.i_done  = 1'b0;
        nxt.d_done  = 1'b0;
        if (!rst) begin
            owner      = 0;
            beats      = 0;
            last_was_d = 1'b0;
            nxt        = '0;
        end else if (owner == 1) begin
            if (mem_ack) begin
                nxt.i_valid = 1'b1;
                nxt.i_idx   = 2'(beats);
                nxt.i_rdata = mem_rdata;
                beats       = beats + 1;
                if (beats == 4) begin
                    nxt.i_done = 1'b1;
                    owner      = 0;
                end
            end
        end else if (owner == 2) begin
            if (mem_ack) begin
                if (!t_we) nxt.d_rdata = mem_rdata;
                nxt.d_done = 1'b1;
                owner      = 0;
            end
        end else begin
            want_i = i_req && !cur.i_done;
            want_d = d_req && !cur.d_done;
            if (want_i && (!want_d || last_was_d)) begin
                owner      = 1;
                base       = i_addr - (i_addr % 32'd16);
                beats      = 0;
                last_was_d = 1'b0;
                t_we       = 1'b0;
                t_be       = 4'hF;
            end else if (want_d) begin
                owner      = 2;
                base       = d_addr - (d_addr % 32'd4);
                beats      = 0;
                last_was_d = 1'b1;
                t_we       = d_we;
                t_wdata    = d_wdata;
                t_be       = d_we ? d_be : 4'hF;
            end
        end
        nxt.mem_req = (owner != 0);
        nxt.busy    = (owner != 0);
        if (owner != 0) begin
            nxt.mem_addr  = base + 32'(4 * beats);
            nxt.mem_we    = t_we;
            nxt.mem_be    = t_be;
            nxt.mem_wdata = t_wdata;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cur = nxt;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_req", mem_req_o, cur.mem_req);
            chk("busy", busy_o, cur.busy);
            chk("i_valid", i_valid_o, cur.i_valid);
            chk("i_done", i_done_o, cur.i_done);
            chk("d_done", d_done_o, cur.d_done);
            chk("d_rdata", d_rdata_o, cur.d_rdata);
            if (cur.mem_req) begin
                chk("mem_addr", mem_addr_o, cur.mem_addr);
                chk("mem_we", mem_we_o, cur.mem_we);
                chk("mem_be", mem_be_o, cur.mem_be);
                if (cur.mem_we) chk("mem_wdata", mem_wdata_o, cur.mem_wdata);
            end
            if (cur.i_valid) begin
                chk("i_idx", i_word_idx_o, cur.i_idx);
                chk("i_rdata", i_rdata_o, cur.i_rdata);
            end
        end
    end

    bit i_pend, d_pend;

    task automatic rand_drive();
        rst = ($urandom_range(0, 249) != 0);
        if (i_pend && i_done_o) begin
            i_pend = 1'b0;
            i_req  = 1'($urandom_range(0, 1));
        end else if (!i_pend && $urandom_range(0, 3) == 0) begin
            i_pend = 1'b1;
            i_req  = 1'b1;
            i_addr = $urandom;
        end else begin
            i_req = i_pend;
        end
        if (d_pend && d_done_o) begin
            d_pend = 1'b0;
            d_req  = 1'($urandom_range(0, 1));
        end else if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend  = 1'b1;
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
        end else begin
            d_req = d_pend;
        end
        mem_ack   = ($urandom_range(0, 2) != 0);
        mem_rdata = $urandom;
    endtask

    initial begin
        cur = '0;
        // Reset held two cycles with both requests pending.
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h0000_1234;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0208; d_wdata = '0; d_be = 4'h3;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        cmp_en = 1;
        tick();
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_i_valid", i_valid_o, 0);

        // First tie after reset goes to the data side.
        rst = 1'b1;
        tick();
        chk("tie1_req", mem_req_o, 1);
        chk("tie1_addr", mem_addr_o, 32'h0000_0208);
        chk("tie1_be", mem_be_o, 4'hF);
        mem_rdata = 32'hCAFE_0001;
        tick();
        chk("load_done", d_done_o, 1);
        chk("load_rdata", d_rdata_o, 32'hCAFE_0001);
        chk("load_req_drop", mem_req_o, 0);
        tick();
        chk("refill_after_d", mem_req_o, 1);
        d_req = 1'b0;

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst_addr%0d", k), mem_addr_o, 32'h0000_1230 + 32'(4 * k));
            mem_ack = 1'b1; mem_rdata = 32'hA500_0000 + 32'(k);
            tick();
            chk($sformatf("burst_valid%0d", k), i_valid_o, 1);
            chk($sformatf("burst_idx%0d", k), i_word_idx_o, 32'(k));
            chk($sformatf("burst_data%0d", k), i_rdata_o, 32'hA500_0000 + 32'(k));
            chk($sformatf("burst_done%0d", k), i_done_o, 32'(k == 3));
        end
        chk("burst_end_req", mem_req_o, 0);

        // Store with a three-cycle ack delay; stale refill request is ignored.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0102;
        d_wdata = 32'hDEAD_BEEF; d_be = 4'b1100; mem_ack = 1'b0;
        tick();
        i_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("st_req%0d", j), mem_req_o, 1);
            chk($sformatf("st_addr%0d", j), mem_addr_o, 32'h0000_0100);
            chk($sformatf("st_we%0d", j), mem_we_o, 1);
            chk($sformatf("st_wdata%0d", j), mem_wdata_o, 32'hDEAD_BEEF);
            chk($sformatf("st_be%0d", j), mem_be_o, 4'b1100);
            mem_ack = (j == 3);
            mem_rdata = 32'h7777_7777;
            tick();
        end
        chk("st_done", d_done_o, 1);
        chk("st_rdata_kept", d_rdata_o, 32'hCAFE_0001);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Second tie: data went last, so the refill wins; top-of-memory line.
        i_req = 1'b1; i_addr = 32'hFFFF_FFF8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        tick();
        chk("tie2_we", mem_we_o, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("top_addr%0d", k), mem_addr_o, 32'hFFFF_FFF0 + 32'(4 * k));
            mem_ack = 1'b1; mem_rdata = $urandom;
            tick();
            chk($sformatf("top_done%0d", k), i_done_o, 32'(k == 3));
        end
        tick();
        i_req = 1'b0;
        chk("tie2_d_next", mem_addr_o, 32'h0000_0300);
        mem_rdata = 32'h5555_AAAA;
        tick();
        chk("tie2_d_done", d_done_o, 1);
        chk("tie2_d_rdata", d_rdata_o, 32'h5555_AAAA);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Reset during beat 2 abandons the burst; the retry starts from the line base.
        i_req = 1'b1; i_addr = 32'h0000_004C;
        tick();
        mem_ack = 1'b1;
        tick();
        tick();
        chk("mid_beat2_addr", mem_addr_o, 32'h0000_0048);
        rst = 1'b0;
        tick();
        chk("mid_rst_req", mem_req_o, 0);
        chk("mid_rst_done", i_done_o, 0);
        rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("retry_addr%0d", k), mem_addr_o, 32'h0000_0040 + 32'(4 * k));
            mem_rdata = $urandom;
            tick();
            chk($sformatf("retry_idx%0d", k), i_word_idx_o, 32'(k));
        end
        chk("retry_done", i_done_o, 1);
        i_req = 1'b0; mem_ack = 1'b0;
        tick();
        tick();

        // Random traffic against the model.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rand_drive();
            tick();
        end

        @(negedge clk);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
